// File: rtl/wrr_arb_pkg.sv
// Shared definitions for the weighted round-robin arbiter: default weight
// width, index-width helper and the cyclic first-set search.
package wrr_arb_pkg;

  localparam int unsigned WRR_DEFAULT_WEIGHT_W = 4;
  // Upper bound on requesters handled by the search helper.
  localparam int WRR_MAX_IN = 64;

  function automatic int wrr_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of vec[n-1:0] searching upward from last+1, wrapping, with
  // bit 'last' examined last. Built from two masked trailing-zero counts: one
  // over the bits above 'last', one over the whole vector as the wrap case.
  function automatic int wrr_first_cyclic(input logic [WRR_MAX_IN-1:0] vec,
                                          input int n, input int last);
    logic [WRR_MAX_IN-1:0] hi;
    int hi_idx;
    int lo_idx;
    hi     = '0;
    hi_idx = 0;
    lo_idx = 0;
    for (int i = 0; i < WRR_MAX_IN; i++) begin
      if (i > last && i < n) hi[i] = vec[i];
    end
    for (int i = WRR_MAX_IN - 1; i >= 0; i--) begin
      if (hi[i]) hi_idx = i;
      if (vec[i] && i < n) lo_idx = i;
    end
    return (|hi) ? hi_idx : lo_idx;
  endfunction

endpackage

// File: rtl/wrr_arb_out_reg.sv
// Single-entry valid/ready output register for wrr_arb_tree. Only present when
// WRR_ARB_TREE_OUT_REG_EN is defined.
`ifdef WRR_ARB_TREE_OUT_REG_EN
module wrr_arb_out_reg #(
  parameter type         DataType = logic [31:0],
  parameter int unsigned IdxWidth = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  DataType             data_i,
  input  logic [IdxWidth-1:0] idx_i,
  output logic                valid_o,
  input  logic                ready_i,
  output DataType             data_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic                valid_q, valid_d;
  DataType             data_q, data_d;
  logic [IdxWidth-1:0] idx_q, idx_d;

  // Accept a new beat when empty or when the held beat leaves this cycle.
  assign ready_o = ~valid_q | ready_i;

  // Next-state: flush empties, otherwise load on accept or drain on grant.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      idx_d   = '0;
    end else if (valid_i && ready_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
      idx_d   = idx_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Stage register; reset discards any in-flight beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;

endmodule
`endif

// File: rtl/wrr_arb_tree.sv
// Weighted round-robin arbiter: per-input credits, zero-weight masking and
// decision lock-in while stalled. Define WRR_ARB_TREE_OUT_REG_EN to add a
// registered output stage (wrr_arb_out_reg); otherwise the path is combinational.
module wrr_arb_tree import wrr_arb_pkg::*; #(
  parameter int unsigned NumIn       = 8,
  parameter int unsigned DataWidth   = 32,
  parameter type         DataType    = logic [DataWidth-1:0],
  parameter int unsigned WeightWidth = WRR_DEFAULT_WEIGHT_W,
  parameter bit          LockIn      = 1'b1,
  parameter int unsigned IdxWidth    = wrr_idx_width(NumIn)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NumIn-1:0][WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]                  req_i,
  output logic [NumIn-1:0]                  gnt_o,
  input  DataType [NumIn-1:0]               data_i,
  output logic                              req_o,
  input  logic                              gnt_i,
  output DataType                           data_o,
  output logic [IdxWidth-1:0]               idx_o
);

  localparam logic [IdxWidth-1:0] PtrRst = IdxWidth'(NumIn - 1);

  logic [NumIn-1:0]       elig;
  logic [WRR_MAX_IN-1:0]  elig_ext;
  logic                   any_elig;
  logic                   hold;
  logic                   hs;
  logic [IdxWidth-1:0]    search_idx;
  logic [IdxWidth-1:0]    win;
  DataType                arb_data;
  logic [IdxWidth-1:0]    ptr_q, ptr_d;
  logic [WeightWidth-1:0] cnt_q, cnt_d;
  logic                   lock_q, lock_d;
  logic [IdxWidth-1:0]    lock_idx_q, lock_idx_d;

  // Eligibility and winner: locked index, else current holder with credit,
  // else the next eligible input after the holder.
  always_comb begin
    elig     = '0;
    elig_ext = '0;
    for (int i = 0; i < NumIn; i++) begin
      elig[i] = req_i[i] & (weight_i[i] != '0);
    end
    elig_ext[NumIn-1:0] = elig;
    any_elig   = |elig;
    hold       = elig[ptr_q] && (cnt_q != '0);
    search_idx = IdxWidth'(wrr_first_cyclic(elig_ext, int'(NumIn), int'(ptr_q)));
    win        = search_idx;
    if (LockIn && lock_q) begin
      win = lock_idx_q;
    end else if (hold) begin
      win = ptr_q;
    end
    arb_data = any_elig ? data_i[win] : '0;
  end

  // Grant fan-out: only the winner, only on a handshake.
  always_comb begin
    gnt_o = '0;
    if (hs) gnt_o[win] = 1'b1;
  end

  // Credit, pointer and lock next-state; flush overrides any handshake.
  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      ptr_d      = PtrRst;
      cnt_d      = '0;
      lock_d     = 1'b0;
      lock_idx_d = '0;
    end else begin
      if (hs) begin
        if (win == ptr_q && cnt_q != '0) begin
          cnt_d = cnt_q - WeightWidth'(1);
        end else begin
          ptr_d = win;
          cnt_d = weight_i[win] - WeightWidth'(1);
        end
      end
      lock_d     = LockIn && any_elig && !hs;
      lock_idx_d = win;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= PtrRst;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef WRR_ARB_TREE_OUT_REG_EN
  logic ready_int;

  wrr_arb_out_reg #(
    .DataType (DataType),
    .IdxWidth (IdxWidth)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (any_elig),
    .ready_o (ready_int),
    .data_i  (arb_data),
    .idx_i   (win),
    .valid_o (req_o),
    .ready_i (gnt_i),
    .data_o  (data_o),
    .idx_o   (idx_o)
  );

  assign hs = any_elig & ready_int;
`else
  assign req_o  = any_elig;
  assign data_o = arb_data;
  assign idx_o  = any_elig ? win : '0;
  assign hs     = any_elig & gnt_i;
`endif

endmodule

// File: tb/tb_wrr_arb_tree.sv
// Directed bench for wrr_arb_tree (NumIn=4, 8-bit payload, LockIn=1).
// With WRR_ARB_TREE_OUT_REG_EN defined it exercises the registered stage.
module tb_wrr_arb_tree;

  logic             clk;
  logic             rst_i;
  logic             flush_i;
  logic [3:0][3:0]  weight_i;
  logic [3:0]       req_i;
  logic [3:0]       gnt_o;
  logic [3:0][7:0]  data_i;
  logic             req_o;
  logic             gnt_i;
  logic [7:0]       data_o;
  logic [1:0]       idx_o;

  int n_chk = 0;
  int n_err = 0;

  int seq1[7] = '{0, 1, 1, 2, 2, 2, 3};
  int seq2[6] = '{0, 0, 1, 1, 3, 3};
  int seq3[6] = '{3, 0, 1, 1, 1, 2};

  wrr_arb_tree #(
    .NumIn       (4),
    .DataWidth   (8),
    .WeightWidth (4),
    .LockIn      (1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .weight_i (weight_i),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .data_i   (data_i),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .data_o   (data_o),
    .idx_o    (idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight_i[0] = 4'(w0);
    weight_i[1] = 4'(w1);
    weight_i[2] = 4'(w2);
    weight_i[3] = 4'(w3);
  endtask

  // Check the combinational grant of the current cycle, then advance.
  task automatic expect_grant(input string tag, input int idx);
    @(negedge clk);
    chk({tag, "_idx"},  32'(idx_o),  32'(idx));
    chk({tag, "_gnt"},  32'(gnt_o),  32'(1) << idx);
    chk({tag, "_data"}, 32'(data_o), 32'hA0 + 32'(idx));
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    req_i   = 4'b0000;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    req_i   = 4'b0000;
    gnt_i   = 1'b1;
    set_w(1, 1, 1, 1);
    for (int i = 0; i < 4; i++) data_i[i] = 8'hA0 + 8'(i);
    #2;
    chk("rst_req_o",  32'(req_o),  32'h0);
    chk("rst_gnt_o",  32'(gnt_o),  32'h0);
    chk("rst_idx_o",  32'(idx_o),  32'h0);
    chk("rst_data_o", 32'(data_o), 32'h0);
    @(posedge clk); #1;
    rst_i = 1'b0;

`ifdef WRR_ARB_TREE_OUT_REG_EN
    // Registered stage: one-cycle latency, full throughput, hold while stalled.
    req_i = 4'b1111;
    @(negedge clk);
    chk("t6_lat_req", 32'(req_o), 32'h0);
    chk("t6_c0_gnt",  32'(gnt_o), 32'h1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t6_c%0d_req", c + 1), 32'(req_o), 32'h1);
      chk($sformatf("t6_c%0d_idx", c + 1), 32'(idx_o), 32'(c));
      chk($sformatf("t6_c%0d_dat", c + 1), 32'(data_o), 32'hA0 + 32'(c));
      chk($sformatf("t6_c%0d_gnt", c + 1), 32'(gnt_o), 32'(1) << ((c + 1) % 4));
      @(posedge clk); #1;
    end
    gnt_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("t6_stall%0d_req", c), 32'(req_o),  32'h1);
      chk($sformatf("t6_stall%0d_idx", c), 32'(idx_o),  32'h0);
      chk($sformatf("t6_stall%0d_dat", c), 32'(data_o), 32'hA0);
      chk($sformatf("t6_stall%0d_gnt", c), 32'(gnt_o),  32'h0);
      @(posedge clk); #1;
    end
    gnt_i = 1'b1;
    @(negedge clk);
    chk("t6_resume_idx", 32'(idx_o), 32'h0);
    chk("t6_resume_gnt", 32'(gnt_o), 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_next_idx", 32'(idx_o),  32'h1);
    chk("t6_next_dat", 32'(data_o), 32'hA1);
    @(posedge clk); #1;
`else
    // Test 1: weights {1,2,3,1}, 7-cycle pattern; stop mid-turn of input 1.
    set_w(1, 2, 3, 1);
    req_i = 4'b1111;
    for (int c = 0; c < 9; c++) expect_grant($sformatf("t1_c%0d", c), seq1[c % 7]);
    // Flush with a handshake: beat still granted, state cleared.
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_gnt", 32'(gnt_o), 32'h2);
    @(posedge clk); #1;
    flush_i = 1'b0;
    expect_grant("flush_after", 0);

    // Test 2: zero weight masks input 2.
    do_flush();
    set_w(2, 2, 0, 2);
    req_i = 4'b1111;
    for (int c = 0; c < 6; c++) expect_grant($sformatf("t2_c%0d", c), seq2[c]);
    req_i = 4'b0100;
    #1;
    chk("t2_masked_req", 32'(req_o), 32'h0);
    chk("t2_masked_gnt", 32'(gnt_o), 32'h0);
    @(posedge clk); #1;

    // Test 3: input 1 forfeits credit when it drops, reloads on return.
    do_flush();
    set_w(1, 3, 1, 1);
    req_i = 4'b1111;
    expect_grant("t3_a", 0);
    expect_grant("t3_b", 1);
    req_i = 4'b1101;
    expect_grant("t3_drop", 2);
    req_i = 4'b1111;
    for (int c = 0; c < 6; c++) expect_grant($sformatf("t3_c%0d", c), seq3[c]);

    // Test 4: lock-in holds input 0 even when 3 would win by priority.
    do_flush();
    set_w(1, 1, 1, 1);
    req_i = 4'b0100;
    expect_grant("t4_prep", 2);
    req_i = 4'b0101;
    gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t4_stall%0d_idx", c), 32'(idx_o), 32'h0);
      chk($sformatf("t4_stall%0d_gnt", c), 32'(gnt_o), 32'h0);
      chk($sformatf("t4_stall%0d_req", c), 32'(req_o), 32'h1);
      @(posedge clk); #1;
      req_i = 4'b1101;
    end
    gnt_i = 1'b1;
    expect_grant("t4_resume", 0);
    expect_grant("t4_next", 2);
    expect_grant("t4_last", 3);

    // Test 5: async reset mid-burst clears state between clock edges.
    do_flush();
    set_w(2, 1, 3, 1);
    req_i = 4'b1111;
    expect_grant("t5_a", 0);
    expect_grant("t5_b", 0);
    expect_grant("t5_c", 1);
    expect_grant("t5_d", 2);
    gnt_i = 1'b0;
    #1;
    chk("t5_burst_idx", 32'(idx_o), 32'h2);
    rst_i = 1'b1;
    #1;
    chk("t5_async_idx", 32'(idx_o), 32'h0);
    chk("t5_async_gnt", 32'(gnt_o), 32'h0);
    #1;
    rst_i = 1'b0;
    gnt_i = 1'b1;
    expect_grant("t5_post0", 0);
    expect_grant("t5_post1", 0);
    expect_grant("t5_post2", 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wrr_arb_tree.md
# wrr_arb_tree

Weighted round-robin arbiter for N requesters onto one req/gnt output. Each input carries a runtime weight: the number of back-to-back grants it receives per turn. It is the next generation of the team's round-robin arbitration tree and is used where masters need unequal bandwidth shares, for example at AXI/AHB interconnect muxes and DMA channel merges. It adds per-input credits, zero-weight masking, decision lock-in and an optional registered output stage.

## Interface
- `NumIn`, 8: number of requesters, ≥2.
- `DataWidth`, 32: payload width.
- `DataType`, `logic [DataWidth-1:0]`: payload type, overridable.
- `WeightWidth`, 4: width of each weight field.
- `LockIn`, 1: hold the arbitration decision while the output is stalled.
- `IdxWidth`, `$clog2(NumIn)`: derived, do not override.
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `flush_i` input 1: synchronous clear of pointer, credit, lock and output stage.
- `weight_i` input `NumIn×WeightWidth`: grants per turn per input; 0 masks the input.
- `req_i` input `NumIn`: input requests.
- `gnt_o` output `NumIn`: input grants, one-hot or zero.
- `data_i` input `NumIn×DataType`: input payloads.
- `req_o` output 1: output request is valid.
- `gnt_i` input 1: output grant.
- `data_o` output `DataType`: selected payload.
- `idx_o` output `IdxWidth`: index of the selected input.

## Operation
- Eligibility: `e[i] = req_i[i] & (weight_i[i] != 0)`.
- State registers: `ptr_q` (current turn holder), `cnt_q` (credits remaining for the holder), `lock_q`/`lock_idx_q`.
- Winner selection:
  - If `e[ptr_q]` and `cnt_q != 0`, the winner is `ptr_q`.
  - Otherwise the winner is the first eligible index searching cyclically from `ptr_q+1`, wrapping, with `ptr_q` searched last. Fair search: two masked trailing-zero counts.
- Handshake is `req_o & gnt_i` in unregistered mode, or the internal accept in registered mode. On a handshake with winner `w`:
  - `w == ptr_q` and `cnt_q != 0`: `cnt_d = cnt_q-1`.
  - Otherwise: `ptr_d = w`, `cnt_d = weight_i[w]-1`.
- No handshake: `ptr_q` and `cnt_q` hold.
- A holder that drops its request forfeits its remaining credit; the next winner reloads.
- A weight change takes effect at the next reload; the current credit is not touched.
- Lock-in (`LockIn=1`): a valid-but-not-granted winner sets `lock_q`, and the next cycle selects `lock_idx_q` regardless of priority. Upstream must keep that request asserted; deassertion is a protocol violation and is not checked. `LockIn=0`: the winner may change each cycle.
- `req_o = |e`. `req_o=0` when all eligible requests are absent, even if masked inputs request.
- `gnt_o[w] = gnt_i & req_o` for the winner; all other bits 0.
- Reset and flush values:
  - `ptr_q = NumIn-1`, so input 0 has priority first.
  - `cnt_q = 0`, `lock_q = 0`, output stage empty.
  - `req_o = 0` (registered mode), `data_o = '0`, `idx_o = '0`, `gnt_o = '0`.
- Reset asserted mid-transfer: all state clears immediately; an in-flight beat in the output stage is discarded.
- `flush_i` and a handshake in the same cycle: flush wins, and the beat is still granted upstream.

## Timing
- Unregistered mode: `req_i`/`data_i` → `req_o`/`data_o`/`idx_o` and `gnt_i` → `gnt_o` are combinational, zero latency, one beat per cycle.
- Registered mode: the winner is written to the output stage when `ready_int = ~valid_q | gnt_i`.
  - 1-cycle latency from `req_i` to `req_o`, full throughput.
  - `gnt_o` depends combinationally on `gnt_i` through `ready_int` only.
  - The output stage holds `data_o`/`idx_o` stable while `req_o & ~gnt_i`.
- State updates occur on the rising edge after the handshake.

## Configuration
- `WRR_ARB_TREE_OUT_REG_EN` defined: a single-entry pipeline register on `req_o`/`data_o`/`idx_o`, with ready passed through as above. Lock-in then applies at the arbiter side.
- Not defined: purely combinational output path, as in unregistered mode.

## Structure
- Package `wrr_arb_pkg`:
  - `WRR_DEFAULT_WEIGHT_W`.
  - Function `wrr_idx_width(n)`.
  - Helper function for cyclic first-set search.
- Top `wrr_arb_tree` contains: eligibility and winner logic, credit/pointer/lock registers, data mux.
- Sub-module `wrr_arb_out_reg`: the single-entry valid/ready register. It is instantiated only under the macro.

## Test plan
Bench configuration: `NumIn=4`, `gnt_i=1`, unless stated otherwise.
1. All requesting, weights {1,2,3,1}: grant sequence 0,1,1,2,2,2,3,0,… repeating every 7 cycles.
2. Weights {2,2,0,2}, `req_i=4'b1111`: input 2 is never granted; sequence 0,0,1,1,3,3. With `req_i=4'b0100`: `req_o=0`.
3. Input 1 with weight 3 drops its request after 1 grant, others requesting: the next grant goes to 2 and input 1's credit is forfeited. When 1 returns it reloads 3.
4. `LockIn=1`, `gnt_i=0` for 3 cycles while 0 and 2 request with 0 winning: `idx_o` stays 0 throughout. When `gnt_i` returns, input 0 is granted first.
5. Async `rst_i` pulse mid-burst (`cnt_q=2`): registers clear without a clock edge. After release, the first grant goes to input 0 with the full weight.
6. Macro defined: a back-to-back stream shows `req_o` 1 cycle after `req_i`, sustained 1 beat per cycle. `gnt_i` low for 2 cycles holds `data_o` and takes no new grants.
